// File: rtl/program_sequencer.sv
// program_sequencer: fetches words from an asynchronous program ROM and issues them to a multicycle processor.
// Define SEQ_STEP_EN to pause after every completed instruction until a Step cycle.
module program_sequencer (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Step,
   input  logic [7:0] ROM_DATA,
   input  logic       Done,
   output logic [7:0] ADDR,
   output logic [7:0] DIN,
   output logic       Run,
   output logic       Busy,
   output logic       Halted,
   output logic       Fault,
   output logic [7:0] ICOUNT
);
   typedef enum logic [2:0] {IDLE, ISSUE, IMM, WAIT, PAUSE, HALT, FAULT} state_t;
   state_t state;
   state_t done_next;
   logic [2:0] wdog;
   logic [2:0] op;
   logic [7:0] icount_inc;
   assign op = ROM_DATA[6:4];
   assign icount_inc = ICOUNT + {7'd0, ICOUNT != 8'hFF};
`ifdef SEQ_STEP_EN
   assign done_next = PAUSE;
`else
   assign done_next = ISSUE;
   logic unused_step;
   assign unused_step = Step;
`endif
   // ROM is asynchronous, so the issue strobe and data follow ROM_DATA in the same cycle
   assign Run = state == ISSUE && op != 3'b111;
   assign DIN = (state == ISSUE || state == IMM) ? ROM_DATA : 8'h00;
   assign Busy = state inside {ISSUE, IMM, WAIT, PAUSE};
   assign Halted = state == HALT;
   assign Fault = state == FAULT;
   always_ff @(posedge Clk)
      if (Reset) begin
         state <= IDLE;
         ADDR <= 8'd0;
         ICOUNT <= 8'd0;
         wdog <= 3'd0;
      end else
         case (state)
            IDLE, HALT, FAULT:
               if (Start) begin
                  ADDR <= 8'd0;
                  ICOUNT <= 8'd0;
                  state <= ISSUE;
               end
            ISSUE:
               if (op == 3'b111) state <= HALT;
               else begin
                  ADDR <= ADDR + 8'd1;
                  wdog <= 3'd0;
                  state <= op == 3'b001 ? IMM : WAIT;
               end
            IMM: begin
               ADDR <= ADDR + 8'd1;
               if (Done) begin
                  ICOUNT <= icount_inc;
                  state <= done_next;
               end else state <= WAIT;
            end
            WAIT:
               if (Done) begin
                  ICOUNT <= icount_inc;
                  state <= done_next;
               end else if (wdog == 3'd7) state <= FAULT;
               else wdog <= wdog + 3'd1;
`ifdef SEQ_STEP_EN
            PAUSE:
               if (Step) state <= ISSUE;
`endif
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: random and directed programs run against a program-level reference model and a small processor model.
module tb_program_sequencer;
   logic       Clk = 0, Reset = 1, Start = 0, auto_step = 1, step_man = 0, stall = 0;
   logic       Step, Done, Run, Busy, Halted, Fault;
   logic [7:0] ROM_DATA, ADDR, DIN, ICOUNT;
   logic [7:0] rom [256];
   logic [7:0] mr [4];
   logic [7:0] pr [4];
   typedef struct { logic [7:0] addr, word, imm; } exp_t;
   exp_t sb [$];
   int nvec = 0, nfail = 0;

   always #5 Clk = ~Clk;
   assign Step = auto_step | step_man;
   assign ROM_DATA = rom[ADDR];

   program_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Step(Step), .ROM_DATA(ROM_DATA), .Done(Done),
      .ADDR(ADDR), .DIN(DIN), .Run(Run), .Busy(Busy), .Halted(Halted), .Fault(Fault), .ICOUNT(ICOUNT));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // processor: mv/mvi finish one cycle after issue, add/sub three cycles after
   logic       pbusy = 0;
   logic [7:0] ir = 0;
   int         t = 0;
   function automatic int lat(input logic [7:0] w);
      return (w[6:4] == 3'd2 || w[6:4] == 3'd3) ? 3 : 1;
   endfunction
   assign Done = pbusy && !stall && t == lat(ir);
   always @(posedge Clk)
      if (Reset) begin
         pbusy <= 0;
         t <= 0;
         for (int i = 0; i < 4; i++) pr[i] <= 8'd0;
      end else if (Run) begin
         pbusy <= 1;
         ir <= DIN;
         t <= 1;
      end else if (!Busy) pbusy <= 0;
      else if (pbusy) begin
         if (Done) begin
            pbusy <= 0;
            case (ir[6:4])
               3'd1: pr[ir[3:2]] <= DIN;
               3'd2: pr[ir[3:2]] <= pr[ir[3:2]] + pr[ir[1:0]];
               3'd3: pr[ir[3:2]] <= pr[ir[3:2]] - pr[ir[1:0]];
               default: pr[ir[3:2]] <= pr[ir[1:0]];
            endcase
         end else t <= t + 1;
      end

   // reference: walk the program, queue every expected issue, execute it on model registers
   task automatic model(input int limit, output logic [7:0] epc, output logic [7:0] eic);
      logic [7:0] pc, nxt, w;
      logic [1:0] x, y;
      int ic, n;
      exp_t e;
      pc = 0; ic = 0; n = 0;
      while (1) begin
         w = rom[pc];
         nxt = pc + 8'd1;
         if (w[6:4] == 3'd7 || n == limit) break;
         e.addr = pc; e.word = w; e.imm = rom[nxt];
         sb.push_back(e);
         n++;
         x = w[3:2]; y = w[1:0];
         case (w[6:4])
            3'd1: mr[x] = rom[nxt];
            3'd2: mr[x] = mr[x] + mr[y];
            3'd3: mr[x] = mr[x] - mr[y];
            default: mr[x] = mr[y];
         endcase
         pc = (w[6:4] == 3'd1) ? pc + 8'd2 : nxt;
         ic = ic < 255 ? ic + 1 : 255;
      end
      epc = pc;
      eic = 8'(ic);
   endtask

   // monitor: every Run pops one expectation
   int cyc = 0, done_cyc = 0;
   bit done_seen = 0, prev_run = 0, imm_pend = 0;
   logic [7:0] imm_exp = 0;
   always @(negedge Clk) begin
      exp_t e;
      cyc++;
      if (Run) begin
         if (sb.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL unexpected_run: got ADDR=%0h DIN=%0h expected no issue", ADDR, DIN);
         end else begin
            e = sb.pop_front();
            check("issue", 32'({ADDR, DIN}), 32'({e.addr, e.word}));
            imm_exp = e.imm;
         end
         check("run_single", 32'(prev_run), 0);
`ifndef SEQ_STEP_EN
         if (done_seen) check("done_gap", cyc - done_cyc, 1);
`endif
         done_seen = 0;
         imm_pend = DIN[6:4] == 3'd1;
      end else if (imm_pend) begin
         check("imm_din", 32'(DIN), 32'(imm_exp));
         imm_pend = 0;
      end
      if (!Busy) done_seen = 0;
      else if (Done) begin
         done_seen = 1;
         done_cyc = cyc;
      end
      prev_run = Run;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
      #1;
   endtask

   task automatic start_pulse;
      Start = 1;
      tick(1);
      Start = 0;
   endtask

   task automatic fill(input logic [7:0] w);
      for (int i = 0; i < 256; i++) rom[i] = w;
   endtask

   task automatic wait_end;
      for (int i = 0; i < 3000 && !(Halted || Fault); i++) tick(1);
   endtask

   task automatic run_prog(input string name);
      logic [7:0] epc, eic;
      model(100000, epc, eic);
      start_pulse();
      wait_end();
      check({name, "_halted"}, 32'(Halted), 1);
      check({name, "_addr"}, 32'(ADDR), 32'(epc));
      check({name, "_icount"}, 32'(ICOUNT), 32'(eic));
      check({name, "_drain"}, sb.size(), 0);
      check({name, "_regs"}, {pr[0], pr[1], pr[2], pr[3]}, {mr[0], mr[1], mr[2], mr[3]});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] save [4];
      logic [7:0] epc, eic, w;
      int k, len;
      fill(8'h70);
      for (int i = 0; i < 4; i++) mr[i] = 8'd0;
      tick(2);
      check("reset_state", 32'({ADDR, DIN, Run, Busy, Halted, Fault, ICOUNT}), 0);
      Start = 1;
      tick(1);
      Start = 0;
      check("reset_over_start", 32'(Busy), 0);
      Reset = 0;
      tick(1);

      rom[0] = 8'h10; rom[1] = 8'h05;
      run_prog("mvi_halt");

      fill(8'h70);
      rom[0] = 8'h10; rom[1] = 8'h05; rom[2] = 8'h14; rom[3] = 8'h03; rom[4] = 8'h21;
      run_prog("add_prog");
      check("add_r0", 32'(pr[0]), 32'h08);

      fill(8'h70);
      rom[0] = 8'h21;
      save = mr;
      model(1, epc, eic);
      mr = save;
      stall = 1;
      start_pulse();
      k = 0;
      while (!Fault && k < 20) begin
         tick(1);
         k++;
      end
      check("fault_latency", k, 9);
      check("fault_hold", 32'({ADDR, ICOUNT}), 32'h0100);
      stall = 0;
      model(100000, epc, eic);
      start_pulse();
      check("restart_addr_fault", 32'({ADDR, Fault}), 0);
      wait_end();
      check("restart_halted", 32'({Halted, ADDR, ICOUNT}), 32'({1'b1, epc, eic}));
      check("restart_drain", sb.size(), 0);

      fill(8'h70);
      rom[0] = 8'h21;
      save = mr;
      model(1, epc, eic);
      mr = save;
      start_pulse();
      Start = 1;
      tick(1);
      Start = 0;
      check("start_busy_addr", 32'(ADDR), 1);
      tick(1);
      Reset = 1;
      tick(1);
      check("reset_mid", 32'({ADDR, DIN, Run, Busy, Halted, Fault, ICOUNT}), 0);
      Reset = 0;
      for (int i = 0; i < 4; i++) mr[i] = 8'd0;
      check("reset_mid_drain", sb.size(), 0);

      fill(8'h00);
      model(300, epc, eic);
      start_pulse();
      for (int i = 0; i < 1000 && sb.size() != 0; i++) tick(1);
      check("wrap_drain", sb.size(), 0);
      check("wrap_fault", 32'(Fault), 0);
      check("wrap_icount", 32'(ICOUNT), 32'(eic));
      Reset = 1;
      tick(1);
      Reset = 0;

`ifdef SEQ_STEP_EN
      auto_step = 0;
      fill(8'h70);
      rom[0] = 8'h00; rom[1] = 8'h00;
      model(100000, epc, eic);
      start_pulse();
      tick(4);
      check("step_pause1", 32'({Busy, Halted}), 32'b10);
      check("step_left1", sb.size(), 1);
      step_man = 1;
      tick(1);
      step_man = 0;
      tick(4);
      check("step_left2", sb.size(), 0);
      check("step_pause2", 32'({Busy, Halted}), 32'b10);
      step_man = 1;
      tick(1);
      step_man = 0;
      tick(3);
      check("step_halt", 32'({Halted, ADDR, ICOUNT}), 32'({1'b1, 8'd2, 8'd2}));
      auto_step = 1;
`endif

      for (int p = 0; p < 20; p++) begin
         len = $urandom_range(1, 30);
         for (int i = 0; i < 256; i++) begin
            w = 8'($urandom);
            if (i < len) begin
               if (w[6:4] == 3'd7) w[6] = 1'b0;
            end else w[6:4] = 3'd7;
            rom[i] = w;
         end
         run_prog("rand");
      end

      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
